mem_stream_reader: RTL and testbench

- Stream source for the wordcount kernel's reader interface.
- Responds to a start/done control handshake and streams DATA_WIDTH-bit beats from an internal block RAM on an AXI4-Stream master port, with full backpressure support.
- Sits where the AXI read master would otherwise sit. Used for on-chip datasets and for standalone kernel bring-up without global memory.
- RAM is loaded through a separate write port.

---
 rtl/mem_stream_reader.sv | 133 +++++++++++++
 tb/tb_mem_stream_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: start/done-controlled AXI4-Stream source backed by an
// internal block RAM. The RAM is loaded through a separate write port, and
// each transfer streams ceil(size/beat_bytes) beats starting at
// ctrl_addr_offset. Read addresses wrap modulo the RAM depth.
// Optional feature: define MEM_STREAM_READER_STALL_CNT_EN to add the
// stall_cycles output (backpressure cycle counter).
module mem_stream_reader #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_start,
  output logic                  ctrl_done,
  input  logic [ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [ADDR_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  mem_we,
  input  logic [DEPTH_LOG2-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy
`ifdef MEM_STREAM_READER_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int CW         = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem    [0:(1 << DEPTH_LOG2) - 1];
  // The two FIFO entries double as the RAM output register: a read issued
  // in one cycle lands directly in a FIFO slot and is visible next cycle.
  logic [DATA_WIDTH-1:0] fifo_q [0:1];
  logic                  wr_idx, rd_idx;
  logic [1:0]            fifo_cnt;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         issue_left, total_beats, emit_cnt, size_beats;
  logic                  start_ok, rd_en, pop;
  logic                  unused_addr;

  // Beat count computed one bit wider than the size so the round-up cannot overflow.
  assign size_beats  = ({1'b0, ctrl_xfer_size_in_bytes} + CW'((1 << BEAT_SHIFT) - 1)) >> BEAT_SHIFT;
  assign unused_addr = ^{ctrl_addr_offset[ADDR_WIDTH-1:DEPTH_LOG2+BEAT_SHIFT],
                         ctrl_addr_offset[BEAT_SHIFT-1:0]};

  assign start_ok      = (state == IDLE) && ctrl_start;
  // No reads are ever outstanding outside the FIFO, so occupancy alone gates issue.
  assign rd_en         = (state == READ) && (fifo_cnt != 2'd2);
  assign m_axis_tvalid = (fifo_cnt != 2'd0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? fifo_q[rd_idx] : '0;
  assign m_axis_tlast  = m_axis_tvalid && ((emit_cnt + CW'(1)) == total_beats);
  assign busy          = (state == READ) || (state == DRAIN);
  assign ctrl_done     = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_start) state_nxt = (size_beats == '0) ? DONE : READ;
      READ:    if (rd_en && issue_left == CW'(1)) state_nxt = DRAIN;
      DRAIN:   if (pop && m_axis_tlast) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read pointer, issue/emit counters and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      issue_left  <= '0;
      total_beats <= '0;
      emit_cnt    <= '0;
      wr_idx      <= 1'b0;
      rd_idx      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (start_ok) begin
        rd_ptr      <= ctrl_addr_offset[DEPTH_LOG2+BEAT_SHIFT-1:BEAT_SHIFT];
        issue_left  <= size_beats;
        total_beats <= size_beats;
        emit_cnt    <= '0;
      end
      if (rd_en) begin
        rd_ptr     <= rd_ptr + 1'b1;
        issue_left <= issue_left - CW'(1);
        wr_idx     <= ~wr_idx;
      end
      if (pop) begin
        rd_idx   <= ~rd_idx;
        emit_cnt <= emit_cnt + CW'(1);
      end
      case ({rd_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // RAM load port and read-first read into the FIFO slot.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_en)  fifo_q[wr_idx] <= mem[rd_ptr];
  end

`ifdef MEM_STREAM_READER_STALL_CNT_EN
  // Saturating count of backpressured cycles in the current transfer.
  always_ff @(posedge clk) begin
    if (reset || start_ok)
      stall_cycles <= '0;
    else if (m_axis_tvalid && !m_axis_tready && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: expected beats are pushed from a
// RAM model when a transfer starts and popped by a negedge monitor.
module tb_mem_stream_reader;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int DL = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          ctrl_start;
  logic          ctrl_done;
  logic [AW-1:0] ctrl_addr_offset;
  logic [AW-1:0] ctrl_xfer_size_in_bytes;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          mem_we;
  logic [DL-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
`ifdef MEM_STREAM_READER_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  mem_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy)
`ifdef MEM_STREAM_READER_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t         exp_q[$];
  logic [DW-1:0] model [0:(1 << DL) - 1];

  int n_vec = 0, n_err = 0;
  int cyc = 0, hs_cnt = 0, done_cnt = 0, done_cyc = 0, last_hs = 0, first_vld = 0, stall_tb = 0;
  bit first_seen = 0, bp_on = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard compare, stall stability, done tracking.
  initial begin : mon
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    beat_t         e;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_vld", m_axis_tvalid, 1);
          chk("hold_data", m_axis_tdata, prev_data);
          chk("hold_last", m_axis_tlast, prev_last);
        end
        if (m_axis_tvalid && !first_seen) begin
          first_seen = 1;
          first_vld  = cyc;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          hs_cnt++;
          last_hs = cyc;
          if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("beat_data", m_axis_tdata, e.d);
            chk("beat_last", m_axis_tlast, e.l);
          end
        end
        if (m_axis_tvalid && !m_axis_tready) stall_tb++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (ctrl_done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_busy", busy, 0);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    mem_we = 1; mem_waddr = DL'(a); mem_wdata = d; model[a] = d;
    tick();
    mem_we = 0;
  endtask

  function automatic logic [AW:0] nbeats(input logic [AW-1:0] s);
    return ({1'b0, s} + 65'd63) >> 6;
  endfunction

  task automatic push_exp(input logic [AW-1:0] off, input logic [AW:0] beats);
    logic [DL-1:0] p;
    beat_t         b;
    p = off[DL+5:6];
    for (int i = 0; i < int'(beats); i++) begin
      b.d = model[p];
      b.l = (i == int'(beats) - 1);
      exp_q.push_back(b);
      p++;
    end
  endtask

  task automatic run(input logic [AW-1:0] off, input logic [AW-1:0] size,
                     input bit bp, input bit dup, input string tag);
    int beats, d0, start_cyc, budget;
    beats  = int'(nbeats(size));
    budget = beats * 4 + 40;
    push_exp(off, nbeats(size));
    bp_on = bp; first_seen = 0; stall_tb = 0; d0 = done_cnt;
    ctrl_addr_offset = off; ctrl_xfer_size_in_bytes = size; ctrl_start = 1;
    start_cyc = cyc;
    tick();
    ctrl_start = 0;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      if (dup && i == 1) chk({tag, "_busy"}, busy, 1);
      if (dup && i == 2) begin ctrl_addr_offset = 64'd500 << 6; ctrl_start = 1; end
      if (dup && i == 3) ctrl_start = 0;
      tick();
    end
    bp_on = 0;
    chk({tag, "_done"}, done_cnt - d0, 1);
    if (beats == 0) begin
      chk({tag, "_done_lat"}, done_cyc - start_cyc, 1);
      chk({tag, "_no_vld"}, first_seen, 0);
    end else begin
      chk({tag, "_first_lat"}, first_vld - start_cyc, 2);
      chk({tag, "_done_lat"}, done_cyc - last_hs, 1);
      if (!bp) chk({tag, "_no_bubble"}, last_hs - first_vld, beats - 1);
    end
    chk({tag, "_q_empty"}, exp_q.size(), 0);
`ifdef MEM_STREAM_READER_STALL_CNT_EN
    chk({tag, "_stall_cnt"}, stall_cycles, stall_tb);
`endif
    chk({tag, "_busy_after"}, busy, 0);
    repeat (2) tick();
  endtask

  initial begin : main
    logic [DW-1:0] pat;
    int d0, h0;
    reset = 1; ctrl_start = 0; ctrl_addr_offset = '0; ctrl_xfer_size_in_bytes = '0;
    mem_we = 0; mem_waddr = '0; mem_wdata = '0; m_axis_tready = 1;
    repeat (3) tick();
    reset = 0;
    @(negedge clk);
    chk("rst_done", ctrl_done, 0);
    chk("rst_vld", m_axis_tvalid, 0);
    chk("rst_last", m_axis_tlast, 0);
    chk("rst_data", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    tick();

    pat = {{14{32'h01234567}}, 32'h89abcdef, 32'h11c0ffee};
    load(0, pat);
    run(64'd0, 64'd64, 0, 0, "single");

    for (int n = 0; n < 128; n++) load(n, DW'(n));
    run(64'h8000_0000, 64'd8192, 0, 0, "stream");
    run(64'h8000_0000, 64'd8192, 1, 0, "bp");

    load(1023, DW'(64'hdead_beef_0000_03ff));
    run(64'd1023 << 6, 64'd130, 0, 0, "wrap");
    run(64'd0, 64'd0, 0, 0, "size0");
    run(64'd5 << 6, 64'd1, 0, 0, "size1");

    // Abort a 20-beat transfer after 5 accepted beats.
    push_exp(64'd10 << 6, 65'd20);
    d0 = done_cnt; h0 = hs_cnt;
    ctrl_addr_offset = 64'd10 << 6; ctrl_xfer_size_in_bytes = 64'd1280; ctrl_start = 1;
    tick();
    ctrl_start = 0;
    for (int i = 0; i < 100 && hs_cnt - h0 < 5; i++) tick();
    chk("mid_hs5", (hs_cnt - h0) >= 5, 1);
    reset = 1;
    tick();
    reset = 0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_vld", m_axis_tvalid, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (30) tick();
    chk("mid_no_done", done_cnt - d0, 0);

    run(64'd20 << 6, 64'd256, 0, 0, "post_rst");
    run(64'd40 << 6, 64'd640, 0, 1, "dup");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
